pulse_event_counter: RTL and testbench
======================================

// Module: pulse_event_counter
// PURPOSE
//  Slow-domain consumer of the single-cycle pulses produced by the fast->slow pulse detector.
//  Counts pulses over fixed windows of WINDOW clk_slow cycles.
//  Each window's count goes out through a valid/ready handshake.
//  Reports overrun when a result is lost to an unaccepted predecessor.
// PARAMETERS
//  CNT_W   8   width of accumulator and reported count (saturating)
//  WINDOW  16  window length in clk_slow cycles; legal range 2..2^16
//  WIN_W   $clog2(WINDOW)  window timer width (derived; do not override)
// PORTS
//  clk_slow     in   1      sole clock; all logic on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  en           in   1      1 = counting enabled; 0 = idle, partial window discarded
//  pulse_in     in   1      single-cycle event pulse (detector dataout)
//  cnt_out      out  CNT_W  pulse count of last completed window
//  cnt_valid    out  1      cnt_out holds an unconsumed result
//  cnt_ready    in   1      consumer accepts cnt_out when cnt_valid & cnt_ready
//  overrun      out  1      sticky: a result was overwritten before acceptance
//  overrun_clr  in   1      synchronous clear of overrun
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, timer=0, acc=0; cnt_out=0, cnt_valid=0, overrun=0.
//  FSM states: IDLE, COUNT.
//  IDLE:
//   timer=0, acc=0.
//   en=1 -> COUNT next cycle; a pulse_in in that transition cycle is not counted.
//  COUNT (en=1): every cycle timer++, and acc++ if pulse_in=1.
//   acc saturates at 2^CNT_W-1 and never wraps.
//  Window close (COUNT & timer==WINDOW-1):
//   result = sat(acc + pulse_in): a pulse in the last cycle is counted in this window.
//   Next edge: cnt_out<=result, cnt_valid<=1, acc<=0, timer<=0; FSM stays in COUNT.
//   Windows run back-to-back with no dead cycle.
//  en=0 while in COUNT -> IDLE next cycle:
//   partial window discarded; acc and timer cleared.
//   A pending cnt_valid/cnt_out is kept until accepted.
//  Handshake:
//   cnt_valid stays high and cnt_out stays stable until the cycle with cnt_valid & cnt_ready.
//   cnt_valid falls on the following edge unless a new result loads on that same edge.
//   cnt_ready while cnt_valid=0 is ignored.
//   Latency: cnt_valid rises 1 cycle after the last window cycle.
//  Simultaneous window close and accept: old value transfers; new value loads; cnt_valid stays 1; no overrun.
//  Window close with cnt_valid=1 and cnt_ready=0:
//   new result overwrites cnt_out, cnt_valid stays 1, overrun<=1.
//  overrun_clr=1 clears overrun. If a set occurs in the same cycle, the set wins.
//  Reset mid-window: everything returns to reset values immediately; no partial result is emitted.
// CONFIGURATION
//  PULSE_EVT_THRESH_EN defined:
//   adds ports thresh (in, CNT_W) and thresh_hit (out, 1).
//   thresh_hit <= (result >= thresh), registered on the same edge as cnt_out loads.
//   thresh_hit is held with cnt_out and reset to 0.
//  PULSE_EVT_THRESH_EN undefined: both ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package pulse_evt_pkg:
//   state typedef enum {IDLE, COUNT}.
//   default localparams CNT_W_DEF=8, WINDOW_DEF=16.
//  Sub-module pulse_win_timer (WINDOW, WIN_W):
//   inputs clr, run; output last (timer==WINDOW-1).
//   Counter wraps to 0 after last.
//  Top level holds the FSM, saturating accumulator, output/handshake registers and overrun flag.
// TESTING (WINDOW=16, CNT_W=8 unless stated)
//  1. en=1 from cycle 0; 5 pulses in window 1, cnt_ready=1
//     -> cnt_valid 1 cycle after window end, cnt_out=5, next window result=0.
//  2. Pulse in the last cycle of a window
//     -> counted in that window, not the next.
//  3. CNT_W=4; 20 pulses in a WINDOW=32 window
//     -> cnt_out=15 (saturated), no wrap.
//  4. cnt_ready=0 across two window closes
//     -> cnt_out holds the second count, overrun=1.
//     -> overrun_clr then clears it; set-vs-clear in the same cycle leaves overrun=1.
//  5. en dropped mid-window with 3 pulses counted, then re-raised
//     -> no result for the partial window; next full window counts from 0.
//  6. rst_n low mid-window with cnt_valid=1 -> all outputs 0 immediately.
//     With PULSE_EVT_THRESH_EN, thresh=4 and counts 3 then 4 -> thresh_hit 0 then 1.

Source files
------------

// File: rtl/pulse_evt_pkg.sv
// pulse_evt_pkg
//  Shared definitions for the pulse event counter slice: FSM state encoding
//  and the default configuration values used by pulse_event_counter.
package pulse_evt_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned WINDOW_DEF = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage : pulse_evt_pkg

// File: rtl/pulse_win_timer.sv
// pulse_win_timer
//  Window timer for pulse_event_counter. Counts clk_slow cycles while run is
//  high and wraps to 0 after reaching WINDOW-1, so consecutive windows abut.
// Ports
//  clk_slow  in   1  clock
//  rst_n     in   1  asynchronous active-low reset
//  clr       in   1  synchronous clear to 0 (dominates run)
//  run       in   1  advance the timer this cycle
//  last      out  1  timer is at WINDOW-1 (final cycle of the window)
module pulse_win_timer #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned WIN_W  = $clog2(WINDOW)
) (
    input  logic clk_slow,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic last
);

    localparam logic [WIN_W-1:0] LAST_VAL = WIN_W'(WINDOW - 1);

    logic [WIN_W-1:0] r_timer;
    logic [WIN_W-1:0] w_timer_nxt;

    // Next timer value: clear, hold, increment or wrap at the window end
    always_comb begin
        w_timer_nxt = r_timer;
        if (clr) begin
            w_timer_nxt = '0;
        end else if (run) begin
            if (r_timer == LAST_VAL) begin
                w_timer_nxt = '0;
            end else begin
                w_timer_nxt = r_timer + WIN_W'(1);
            end
        end
    end

    // Timer register
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_nxt;
        end
    end

    assign last = (r_timer == LAST_VAL);

endmodule : pulse_win_timer

// File: rtl/pulse_event_counter.sv
// pulse_event_counter
//  Slow-domain consumer of single-cycle pulses. Counts pulses over fixed
//  windows of WINDOW clk_slow cycles with a saturating CNT_W-bit accumulator
//  and presents each window's count through a valid/ready handshake. A sticky
//  overrun flag records a result overwritten before it was accepted.
//  Optional feature macro: PULSE_EVT_THRESH_EN adds a threshold compare
//  (thresh in, thresh_hit out) registered alongside cnt_out.
// Ports
//  clk_slow     in   1      sole clock, posedge
//  rst_n        in   1      asynchronous active-low reset
//  en           in   1      counting enable; dropping it discards the partial window
//  pulse_in     in   1      single-cycle event pulse
//  cnt_out      out  CNT_W  count of the last completed window
//  cnt_valid    out  1      cnt_out holds an unconsumed result
//  cnt_ready    in   1      consumer accepts cnt_out when cnt_valid & cnt_ready
//  overrun      out  1      sticky: a result was overwritten before acceptance
//  overrun_clr  in   1      synchronous clear of overrun (a same-cycle set wins)
//  thresh       in   CNT_W  [PULSE_EVT_THRESH_EN] threshold for thresh_hit
//  thresh_hit   out  1      [PULSE_EVT_THRESH_EN] loaded result >= thresh
module pulse_event_counter
    import pulse_evt_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned WINDOW = WINDOW_DEF,
    parameter int unsigned WIN_W  = $clog2(WINDOW)
) (
    input  logic             clk_slow,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overrun,
    input  logic             overrun_clr
`ifdef PULSE_EVT_THRESH_EN
    ,
    input  logic [CNT_W-1:0] thresh,
    output logic             thresh_hit
`endif
);

    localparam int unsigned SUM_W = CNT_W + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt_out;
    logic [CNT_W-1:0] w_cnt_out_nxt;
    logic             r_cnt_valid;
    logic             w_cnt_valid_nxt;
    logic             r_overrun;
    logic             w_overrun_nxt;

    logic             w_tmr_clr;
    logic             w_tmr_run;
    logic             w_last;
    logic             w_close;
    logic             w_accept;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_sat;

    // Window timer
    pulse_win_timer #(
        .WINDOW (WINDOW),
        .WIN_W  (WIN_W)
    ) u_timer (
        .clk_slow (clk_slow),
        .rst_n    (rst_n),
        .clr      (w_tmr_clr),
        .run      (w_tmr_run),
        .last     (w_last)
    );

    // Saturating accumulate; also the window result when the window closes,
    // so a pulse in the final cycle lands in the closing window.
    assign w_sum = {1'b0, r_acc} + SUM_W'(pulse_in);
    assign w_sat = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    assign w_accept = r_cnt_valid & cnt_ready;

    // Next-state, accumulator, timer control and output-register next values
    always_comb begin
        w_state_nxt     = r_state;
        w_tmr_clr       = 1'b1;
        w_tmr_run       = 1'b0;
        w_acc_nxt       = '0;
        w_close         = 1'b0;
        w_cnt_out_nxt   = r_cnt_out;
        w_cnt_valid_nxt = r_cnt_valid;
        w_overrun_nxt   = r_overrun;

        case (r_state)
            IDLE: begin
                // Transition cycle: pulse_in is not counted
                if (en) begin
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    // Partial window discarded; acc and timer clear
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_clr = 1'b0;
                    w_tmr_run = 1'b1;
                    if (w_last) begin
                        w_close = 1'b1;
                    end else begin
                        w_acc_nxt = w_sat;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A closing window always loads, even over an unaccepted result
        if (w_close) begin
            w_cnt_out_nxt   = w_sat;
            w_cnt_valid_nxt = 1'b1;
        end else if (w_accept) begin
            w_cnt_valid_nxt = 1'b0;
        end

        // Lost result sets overrun; a set beats a same-cycle clear
        if (w_close && r_cnt_valid && !cnt_ready) begin
            w_overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            w_overrun_nxt = 1'b0;
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt_out   <= w_cnt_out_nxt;
            r_cnt_valid <= w_cnt_valid_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign cnt_out   = r_cnt_out;
    assign cnt_valid = r_cnt_valid;
    assign overrun   = r_overrun;

`ifdef PULSE_EVT_THRESH_EN
    logic r_thresh_hit;

    // Threshold flag loads with cnt_out and is held with it
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh_hit <= 1'b0;
        end else if (w_close) begin
            r_thresh_hit <= (w_sat >= thresh);
        end
    end

    assign thresh_hit = r_thresh_hit;
`endif

endmodule : pulse_event_counter

// File: tb/tb_pulse_event_counter.sv
// tb_pulse_event_counter
//  Self-checking bench for pulse_event_counter. Main instance uses CNT_W=8,
//  WINDOW=16; a second instance (CNT_W=4, WINDOW=32) covers saturation.
//  Expected counts come from per-window pulse patterns: popcount clamped to
//  the counter maximum. Define PULSE_EVT_THRESH_EN to include thresh checks.
module tb_pulse_event_counter;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned WINDOW   = 16;
    localparam int unsigned S_CNT_W  = 4;
    localparam int unsigned S_WINDOW = 32;

    logic clk_slow = 1'b0;
    always #5 clk_slow = ~clk_slow;

    logic             rst_n;
    logic             en;
    logic             pulse_in;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             overrun;
    logic             overrun_clr;

    logic               s_en;
    logic               s_pulse_in;
    logic [S_CNT_W-1:0] s_cnt_out;
    logic               s_cnt_valid;
    logic               s_cnt_ready;
    logic               s_overrun;
    logic               s_overrun_clr;

`ifdef PULSE_EVT_THRESH_EN
    logic [CNT_W-1:0]   thresh;
    logic               thresh_hit;
    logic [S_CNT_W-1:0] s_thresh;
    logic               s_thresh_hit;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pulse_event_counter #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
        .clk_slow    (clk_slow),
        .rst_n       (rst_n),
        .en          (en),
        .pulse_in    (pulse_in),
        .cnt_out     (cnt_out),
        .cnt_valid   (cnt_valid),
        .cnt_ready   (cnt_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef PULSE_EVT_THRESH_EN
        ,
        .thresh      (thresh),
        .thresh_hit  (thresh_hit)
`endif
    );

    pulse_event_counter #(.CNT_W(S_CNT_W), .WINDOW(S_WINDOW)) dut_sat (
        .clk_slow    (clk_slow),
        .rst_n       (rst_n),
        .en          (s_en),
        .pulse_in    (s_pulse_in),
        .cnt_out     (s_cnt_out),
        .cnt_valid   (s_cnt_valid),
        .cnt_ready   (s_cnt_ready),
        .overrun     (s_overrun),
        .overrun_clr (s_overrun_clr)
`ifdef PULSE_EVT_THRESH_EN
        ,
        .thresh      (s_thresh),
        .thresh_hit  (s_thresh_hit)
`endif
    );

    // Reference model: a window's count is its pulse popcount, clamped
    function automatic int exp_count(input logic [31:0] pat, input int n, input int maxv);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(pat[i]);
        return (s > maxv) ? maxv : s;
    endfunction

    // Pattern with exactly k pulses at random positions in n cycles
    function automatic logic [31:0] make_pat(input int n, input int k);
        logic [31:0] p = '0;
        while ($countones(p) < k) p[$urandom_range(n - 1, 0)] = 1'b1;
        return p;
    endfunction

    function automatic logic [31:0] rand_pat(input int n);
        logic [31:0] p = $urandom;
        if (n < 32) p = p & ((32'd1 << n) - 32'd1);
        return p;
    endfunction

    // Each tick: set inputs, advance one clock; returns at the next negedge
    task automatic tick(input logic p);
        pulse_in = p;
        @(negedge clk_slow);
    endtask

    task automatic s_tick(input logic p);
        s_pulse_in = p;
        @(negedge clk_slow);
    endtask

    task automatic drive(input logic [31:0] pat, input int first, input int last_i);
        for (int c = first; c <= last_i; c++) tick(pat[c]);
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        en            = 1'b0;
        pulse_in      = 1'b0;
        cnt_ready     = 1'b0;
        overrun_clr   = 1'b0;
        s_en          = 1'b0;
        s_pulse_in    = 1'b0;
        s_cnt_ready   = 1'b0;
        s_overrun_clr = 1'b0;
`ifdef PULSE_EVT_THRESH_EN
        thresh   = '0;
        s_thresh = '0;
`endif
        repeat (2) @(negedge clk_slow);
        rst_n = 1'b1;
        @(negedge clk_slow);
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (cnt_out !== '0 || cnt_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: cnt_out=%0d cnt_valid=%0b overrun=%0b, expected all 0",
                     cnt_out, cnt_valid, overrun);
        end
        n_tests++;
        if (s_cnt_out !== '0 || s_cnt_valid !== 1'b0 || s_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sat: cnt_out=%0d cnt_valid=%0b overrun=%0b, expected all 0",
                     s_cnt_out, s_cnt_valid, s_overrun);
        end
    endtask

    // Back-to-back windows with ready held high; first has 5 pulses, second none
    task automatic test_basic();
        logic [31:0] pat;
        int          exp;
        apply_reset();
        cnt_ready = 1'b1;
        en        = 1'b1;
        tick(1'($urandom));
        for (int w = 0; w < 5; w++) begin
            pat = (w == 0) ? make_pat(16, 5) : (w == 1) ? 32'd0 : rand_pat(16);
            exp = exp_count(pat, 16, 255);
            drive(pat, 0, 14);
            n_tests++;
            if (cnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_latency_w%0d: cnt_valid=%0b, expected 0", w, cnt_valid);
            end
            tick(pat[15]);
            n_tests++;
            if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp) || overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_w%0d: valid=%0b cnt_out=%0d overrun=%0b, expected 1 %0d 0",
                         w, cnt_valid, cnt_out, overrun, exp);
            end
        end
        en = 1'b0;
        tick(1'b0);
        n_tests++;
        if (cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: cnt_valid=%0b, expected 0", cnt_valid);
        end
        tick(1'b0);
    endtask

    // A pulse in the final window cycle belongs to that window
    task automatic test_last_cycle();
        apply_reset();
        cnt_ready = 1'b1;
        en        = 1'b1;
        tick(1'b0);
        drive(32'h0000_8000, 0, 15);
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL last_cycle_w0: valid=%0b cnt_out=%0d, expected 1 1", cnt_valid, cnt_out);
        end
        drive(32'd0, 0, 15);
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL last_cycle_w1: valid=%0b cnt_out=%0d, expected 1 0", cnt_valid, cnt_out);
        end
        en = 1'b0;
        tick(1'b0);
        tick(1'b0);
    endtask

    // Narrow counter saturates instead of wrapping
    task automatic test_saturate();
        logic [31:0] pat;
        int          exp;
        s_cnt_ready = 1'b1;
        s_en        = 1'b1;
        s_tick(1'b1);
        for (int w = 0; w < 2; w++) begin
            pat = (w == 0) ? make_pat(32, 20) : rand_pat(32);
            exp = exp_count(pat, 32, 15);
            for (int c = 0; c < 31; c++) s_tick(pat[c]);
            n_tests++;
            if (s_cnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_latency_w%0d: cnt_valid=%0b, expected 0", w, s_cnt_valid);
            end
            s_tick(pat[31]);
            n_tests++;
            if (s_cnt_valid !== 1'b1 || s_cnt_out !== S_CNT_W'(exp)) begin
                n_fail++;
                $display("FAIL sat_w%0d: valid=%0b cnt_out=%0d, expected 1 %0d",
                         w, s_cnt_valid, s_cnt_out, exp);
            end
        end
        s_en = 1'b0;
        s_tick(1'b0);
        s_tick(1'b0);
    endtask

    // Overwrite with ready low, clear, set-vs-clear, and close-with-accept
    task automatic test_overrun();
        logic [31:0] pa, pb, pc, pd;
        apply_reset();
        cnt_ready = 1'b0;
        en        = 1'b1;
        tick(1'b0);
        pa = rand_pat(16);
        pb = rand_pat(16);
        pc = rand_pat(16);
        pd = rand_pat(16);
        drive(pa, 0, 15);
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp_count(pa, 16, 255)) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first: valid=%0b cnt_out=%0d overrun=%0b, expected 1 %0d 0",
                     cnt_valid, cnt_out, overrun, exp_count(pa, 16, 255));
        end
        drive(pb, 0, 7);
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp_count(pa, 16, 255))) begin
            n_fail++;
            $display("FAIL ovr_hold: valid=%0b cnt_out=%0d, expected 1 %0d",
                     cnt_valid, cnt_out, exp_count(pa, 16, 255));
        end
        drive(pb, 8, 15);
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp_count(pb, 16, 255)) || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: valid=%0b cnt_out=%0d overrun=%0b, expected 1 %0d 1",
                     cnt_valid, cnt_out, overrun, exp_count(pb, 16, 255));
        end
        overrun_clr = 1'b1;
        tick(pc[0]);
        overrun_clr = 1'b0;
        n_tests++;
        if (overrun !== 1'b0 || cnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_clr: overrun=%0b valid=%0b, expected 0 1", overrun, cnt_valid);
        end
        drive(pc, 1, 14);
        overrun_clr = 1'b1;
        tick(pc[15]);
        overrun_clr = 1'b0;
        n_tests++;
        if (overrun !== 1'b1 || cnt_out !== CNT_W'(exp_count(pc, 16, 255))) begin
            n_fail++;
            $display("FAIL ovr_set_wins: overrun=%0b cnt_out=%0d, expected 1 %0d",
                     overrun, cnt_out, exp_count(pc, 16, 255));
        end
        overrun_clr = 1'b1;
        tick(pd[0]);
        overrun_clr = 1'b0;
        drive(pd, 1, 14);
        cnt_ready = 1'b1;
        tick(pd[15]);
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp_count(pd, 16, 255)) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_close_accept: valid=%0b cnt_out=%0d overrun=%0b, expected 1 %0d 0",
                     cnt_valid, cnt_out, overrun, exp_count(pd, 16, 255));
        end
        en = 1'b0;
        tick(1'b0);
        n_tests++;
        if (cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_drain: cnt_valid=%0b, expected 0", cnt_valid);
        end
        tick(1'b0);
    endtask

    // Dropping en discards the partial window but keeps a pending result
    task automatic test_en_drop();
        logic [31:0] p0, pp, pf;
        apply_reset();
        cnt_ready = 1'b0;
        en        = 1'b1;
        tick(1'b0);
        p0 = rand_pat(16);
        pp = make_pat(6, 3);
        pf = rand_pat(16);
        drive(p0, 0, 15);
        drive(pp, 0, 5);
        en = 1'b0;
        tick(1'b1);
        repeat (3) tick(1'($urandom));
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp_count(p0, 16, 255)) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_pending: valid=%0b cnt_out=%0d overrun=%0b, expected 1 %0d 0",
                     cnt_valid, cnt_out, overrun, exp_count(p0, 16, 255));
        end
        cnt_ready = 1'b1;
        tick(1'b0);
        n_tests++;
        if (cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_accept: cnt_valid=%0b, expected 0", cnt_valid);
        end
        en = 1'b1;
        tick(1'b1);
        drive(pf, 0, 14);
        n_tests++;
        if (cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_no_partial: cnt_valid=%0b, expected 0", cnt_valid);
        end
        tick(pf[15]);
        n_tests++;
        if (cnt_valid !== 1'b1 || cnt_out !== CNT_W'(exp_count(pf, 16, 255))) begin
            n_fail++;
            $display("FAIL en_drop_full: valid=%0b cnt_out=%0d, expected 1 %0d",
                     cnt_valid, cnt_out, exp_count(pf, 16, 255));
        end
        en = 1'b0;
        tick(1'b0);
        tick(1'b0);
    endtask

    // Asynchronous reset mid-window with a pending result and overrun set
    task automatic test_reset_mid();
        apply_reset();
        cnt_ready = 1'b0;
        en        = 1'b1;
        tick(1'b0);
        drive(rand_pat(16) | 32'd1, 0, 15);
        drive(rand_pat(16) | 32'd1, 0, 15);
        n_tests++;
        if (cnt_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: valid=%0b overrun=%0b, expected 1 1", cnt_valid, overrun);
        end
        drive(rand_pat(16), 0, 6);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (cnt_out !== '0 || cnt_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: cnt_out=%0d valid=%0b overrun=%0b, expected 0 0 0",
                     cnt_out, cnt_valid, overrun);
        end
`ifdef PULSE_EVT_THRESH_EN
        n_tests++;
        if (thresh_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_thresh: thresh_hit=%0b, expected 0", thresh_hit);
        end
`endif
        @(negedge clk_slow);
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick(1'b1);
        n_tests++;
        if (cnt_valid !== 1'b0 || cnt_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after: valid=%0b cnt_out=%0d, expected 0 0", cnt_valid, cnt_out);
        end
    endtask

`ifdef PULSE_EVT_THRESH_EN
    // thresh_hit tracks the loaded result against thresh and holds with it
    task automatic test_thresh();
        logic [31:0] pat;
        int          exp;
        apply_reset();
        thresh    = CNT_W'(4);
        cnt_ready = 1'b1;
        en        = 1'b1;
        tick(1'b0);
        for (int w = 0; w < 4; w++) begin
            pat = (w == 0) ? make_pat(16, 3) : (w == 1) ? make_pat(16, 4) : rand_pat(16);
            exp = exp_count(pat, 16, 255);
            drive(pat, 0, 15);
            n_tests++;
            if (thresh_hit !== (exp >= 4) || cnt_out !== CNT_W'(exp)) begin
                n_fail++;
                $display("FAIL thresh_w%0d: thresh_hit=%0b cnt_out=%0d, expected %0b %0d",
                         w, thresh_hit, cnt_out, (exp >= 4), exp);
            end
        end
        en = 1'b0;
        tick(1'b0);
        n_tests++;
        if (thresh_hit !== (exp >= 4)) begin
            n_fail++;
            $display("FAIL thresh_hold: thresh_hit=%0b, expected %0b", thresh_hit, (exp >= 4));
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_last_cycle();
        test_saturate();
        test_overrun();
        test_en_drop();
        test_reset_mid();
`ifdef PULSE_EVT_THRESH_EN
        test_thresh();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule : tb_pulse_event_counter
